// File: rtl/prog_loader.sv
// Boot-time program loader: streams instruction words into program memory from address 0,
// holds the core in reset during the load. Optional checksum word: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 256,
  parameter int RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              reload,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERR} state_t;

  localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [3:0]      HOLD_INI = 4'(RST_HOLD - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic       accept;
  logic       full;

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign accept   = in_valid && in_ready;
  assign full     = (word_count == MAX_CNT);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nxt;
  assign sum_nxt = sum + in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      core_rst   <= 1'b1;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      pm_we <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            // The last word is the checksum itself: never written or counted.
            if (in_last) begin
              if (sum_nxt == '0) begin
                state    <= S_HOLD;
                hold_cnt <= HOLD_INI;
              end else begin
                state    <= S_ERR;
                load_err <= 1'b1;
              end
            end else if (full) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              pm_we      <= 1'b1;
              pm_addr    <= word_count[ADDR_W-1:0];
              pm_wdata   <= in_data;
              word_count <= word_count + 1'b1;
              sum        <= sum_nxt;
              state      <= S_LOAD;
            end
`else
            if (full) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              pm_we      <= 1'b1;
              pm_addr    <= word_count[ADDR_W-1:0];
              pm_wdata   <= in_data;
              word_count <= word_count + 1'b1;
              if (in_last) begin
                state    <= S_HOLD;
                hold_cnt <= HOLD_INI;
              end else begin
                state    <= S_LOAD;
              end
            end
`endif
          end
        end
        S_HOLD: begin
          // HOLD lasts RST_HOLD cycles so the core sees reset well after the last write.
          if (hold_cnt == '0) begin
            state     <= S_RUN;
            core_rst  <= 1'b0;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_RUN, S_ERR: begin
          if (reload) begin
            state      <= S_IDLE;
            core_rst   <= 1'b1;
            pm_addr    <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
